axi_dma_master: RTL

AXI_DMA_MASTER -- requirements
Module: axi_dma_master

---
 rtl/utils_pkg.sv | 75 +++++++
 rtl/axi_dma_master.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/utils_pkg.sv
// rtl/utils_pkg.sv - shared AXI types, constants and DMA state encoding
// Purpose: AXI4 master/slave channel bundles plus the constants and FSM
// state type used by axi_dma_master. No ports (package).
package utils_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_USER_W = 1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [2:0] AXI_SIZE_WORD   = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } dma_state_e;

  // Master-driven channels: AW, W, B ready, AR, R ready.
  typedef struct packed {
    logic [AXI_ID_W-1:0]   awid;
    logic [31:0]           awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic [3:0]            awqos;
    logic [3:0]            awregion;
    logic [AXI_USER_W-1:0] awuser;
    logic                  awvalid;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wlast;
    logic [AXI_USER_W-1:0] wuser;
    logic                  wvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   arid;
    logic [31:0]           araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic [3:0]            arregion;
    logic [AXI_USER_W-1:0] aruser;
    logic                  arvalid;
    logic                  rready;
  } s_axi_mosi_t;

  // Slave-driven channels: AW/W ready, B, AR ready, R.
  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic [AXI_USER_W-1:0] buser;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [AXI_USER_W-1:0] ruser;
    logic                  rvalid;
  } s_axi_miso_t;

endpackage

// File: rtl/axi_dma_master.sv
// rtl/axi_dma_master.sv - single-word-at-a-time AXI memory-to-memory copy engine
// Purpose: copies len_words_i 32-bit words from src to dst, one read then one
// write per word, never more than one AXI transaction in flight.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start_i           - start a copy (only honoured in IDLE)
//   src_addr_i        - source byte address (word aligned internally)
//   dst_addr_i        - destination byte address (word aligned internally)
//   len_words_i       - number of words to copy
//   busy_o            - copy in progress
//   done_o            - one-cycle pulse at end of copy (success or abort)
//   err_o             - sticky error, cleared on next accepted start
//   axi_mosi_o        - AXI master request channels
//   axi_miso_i        - AXI slave response channels
module axi_dma_master
  import utils_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] AXI_ID = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  input  logic [15:0] len_words_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output s_axi_mosi_t axi_mosi_o,
  input  s_axi_miso_t axi_miso_i
);

  dma_state_e  state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic        err_q, err_d;
  // AW and W may complete in different cycles; remember which one is done.
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic aw_valid_c, w_valid_c, aw_fire, w_fire;

  assign aw_valid_c = (state_q == ST_WR_REQ) && !aw_done_q;
  assign w_valid_c  = (state_q == ST_WR_REQ) && !w_done_q;
  assign aw_fire    = aw_valid_c && axi_miso_i.awready;
  assign w_fire     = w_valid_c && axi_miso_i.wready;

  // Response fields this engine has no use for, plus the discarded byte offset.
  logic unused_inputs;
  assign unused_inputs = ^{axi_miso_i.bid, axi_miso_i.buser, axi_miso_i.rid,
                           axi_miso_i.rlast, axi_miso_i.ruser,
                           src_addr_i[1:0], dst_addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    // Request fields are driven from the latched registers at all times so
    // they cannot move while a valid waits for its ready.
    axi_mosi_o         = '0;
    axi_mosi_o.arid    = AXI_ID;
    axi_mosi_o.araddr  = src_q;
    axi_mosi_o.arsize  = AXI_SIZE_WORD;
    axi_mosi_o.arburst = AXI_BURST_INCR;
    axi_mosi_o.awid    = AXI_ID;
    axi_mosi_o.awaddr  = dst_q;
    axi_mosi_o.awsize  = AXI_SIZE_WORD;
    axi_mosi_o.awburst = AXI_BURST_INCR;
    axi_mosi_o.wdata   = buf_q;
    axi_mosi_o.wstrb   = 4'hF;
    axi_mosi_o.wlast   = 1'b1;
    axi_mosi_o.awvalid = aw_valid_c;
    axi_mosi_o.wvalid  = w_valid_c;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src_d     = {src_addr_i[31:2], 2'b00};
          dst_d     = {dst_addr_i[31:2], 2'b00};
          cnt_d     = len_words_i;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (len_words_i == 16'd0) ? ST_DONE : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        axi_mosi_o.arvalid = 1'b1;
        if (axi_miso_i.arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        axi_mosi_o.rready = 1'b1;
        if (axi_miso_i.rvalid) begin
          buf_d = axi_miso_i.rdata;
          if (axi_miso_i.rresp == AXI_RESP_OKAY) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_WR_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_WR_REQ: begin
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        axi_mosi_o.bready = 1'b1;
        if (axi_miso_i.bvalid) begin
          if (axi_miso_i.bresp != AXI_RESP_OKAY) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q - 16'd1;
            src_d   = src_q + 32'd4;
            dst_d   = dst_q + 32'd4;
            state_d = (cnt_q == 16'd1) ? ST_DONE : ST_RD_ADDR;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o = (state_q == ST_DONE);
  assign err_o  = err_q;

endmodule
